// File: rtl/key_schedule_seq.sv
// Purpose: sequential AES-128/192/256 key expansion into a round-key buffer, then round-key streaming.
// Latency: first round key valid 4*Nr+4-Nk clocks after the accepted start (40/46/52).
// Backpressure: o_RKey/o_RndIdx/o_Last hold while o_RKeyVld & !i_RKeyRdy; full rate when ready.
// Ports: i_Clk/i_Rst_n clock and async active-low reset; i_Start/i_Key/i_KeyLen/i_fDec launch an
//   expansion (sampled only in IDLE); o_RKey/o_RKeyVld/i_RKeyRdy/o_RndIdx/o_Last stream the round
//   keys (forward for encrypt, reverse for decrypt); o_Busy covers EXPAND and STREAM; o_Err pulses
//   on a start with an unsupported key length.
module key_schedule_seq #(
   parameter int MAX_NK = 8
) (
   input  logic                  i_Clk,
   input  logic                  i_Rst_n,
   input  logic                  i_Start,
   input  logic [32*MAX_NK-1:0]  i_Key,
   input  logic [1:0]            i_KeyLen,
   input  logic                  i_fDec,
   output logic                  o_Busy,
   output logic [127:0]          o_RKey,
   output logic                  o_RKeyVld,
   input  logic                  i_RKeyRdy,
   output logic [3:0]            o_RndIdx,
   output logic                  o_Last,
   output logic                  o_Err
);

   localparam int DEPTH = 4*(MAX_NK+7);
   localparam int AW = $clog2(DEPTH);
   localparam logic [3:0] MAX_NK_W = 4'(MAX_NK);

   typedef enum logic [1:0] {IDLE, EXPAND, STREAM} state_t;

   state_t        state, state_nxt;
   logic [31:0]   rk_mem [DEPTH];
   logic [3:0]    nk, nr, kmod;
   logic          dec;
   logic [AW-1:0] i_q;
   logic [7:0]    rcon;

   logic [3:0]    req_nk, req_nr, ld_r;
   logic          req_legal, start_ok, start_bad, accept, last_word;
   logic [31:0]   w_prev, w_back, t, w_new;
   logic [AW-1:0] base;
   logic [127:0]  key_ld;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Forward S-box: multiplicative inverse (a^254, 0 maps to 0) followed by the affine transform.
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] r;
      logic [7:0] s;
      r = 8'h01;
      s = a;
      for (int k = 1; k < 8; k++) begin
         s = gf_mul(s, s);
         r = gf_mul(r, s);
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   always_comb begin
      req_nk = 4'd0;
      req_nr = 4'd0;
      case (i_KeyLen)
         2'd0:    begin req_nk = 4'd4; req_nr = 4'd10; end
         2'd1:    begin req_nk = 4'd6; req_nr = 4'd12; end
         2'd2:    begin req_nk = 4'd8; req_nr = 4'd14; end
         default: begin req_nk = 4'd0; req_nr = 4'd0;  end
      endcase
   end

   assign req_legal = (i_KeyLen != 2'd3) && (req_nk <= MAX_NK_W);
   assign start_ok  = (state == IDLE) && i_Start && req_legal;
   assign start_bad = (state == IDLE) && i_Start && !req_legal;
   assign accept    = o_RKeyVld && i_RKeyRdy;
   assign last_word = (state == EXPAND) && (i_q == AW'({nr, 2'b11}));
   assign o_Busy    = (state != IDLE);

   // kmod tracks i mod Nk so no divider is needed.
   assign w_prev = rk_mem[i_q - AW'(1)];
   assign w_back = rk_mem[i_q - AW'(nk)];
   always_comb begin
      t = w_prev;
      if (kmod == 4'd0)
         t = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {rcon, 24'h0};
      else if (nk == 4'd8 && kmod == 4'd4)
         t = sub_word(w_prev);
   end
   assign w_new = w_back ^ t;

   // Round whose key is loaded next: the first key at end of expansion, else the neighbour of the current one.
   always_comb begin
      if (state == EXPAND) ld_r = dec ? nr : 4'd0;
      else                 ld_r = dec ? (o_RndIdx - 4'd1) : (o_RndIdx + 4'd1);
   end
   assign base = AW'({ld_r, 2'b00});

   // The decrypt-first key contains the word written on this very edge, so bypass it from w_new.
   always_comb begin
      key_ld = '0;
      for (int k = 0; k < 4; k++) begin
         if (state == EXPAND && (base + AW'(k)) == i_q)
            key_ld[127-32*k -: 32] = w_new;
         else
            key_ld[127-32*k -: 32] = rk_mem[base + AW'(k)];
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_ok) state_nxt = EXPAND;
         EXPAND:  if (last_word) state_nxt = STREAM;
         STREAM:  if (accept && o_Last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Buffer is deliberately not reset.
   always_ff @(posedge i_Clk) begin
      if (start_ok) begin
         for (int k = 0; k < MAX_NK; k++)
            if (4'(k) < req_nk) rk_mem[k] <= i_Key[32*(MAX_NK-k)-1 -: 32];
      end
      if (state == EXPAND) rk_mem[i_q] <= w_new;
   end

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         nk        <= 4'd0;
         nr        <= 4'd0;
         dec       <= 1'b0;
         i_q       <= '0;
         kmod      <= 4'd0;
         rcon      <= 8'h01;
         o_RKey    <= '0;
         o_RKeyVld <= 1'b0;
         o_RndIdx  <= 4'd0;
         o_Last    <= 1'b0;
         o_Err     <= 1'b0;
      end else begin
         o_Err <= start_bad;
         case (state)
            IDLE: begin
               if (start_ok) begin
                  nk   <= req_nk;
                  nr   <= req_nr;
                  dec  <= i_fDec;
                  i_q  <= AW'(req_nk);
                  kmod <= 4'd0;
                  rcon <= 8'h01;
               end
            end
            EXPAND: begin
               i_q  <= i_q + AW'(1);
               kmod <= (kmod == nk - 4'd1) ? 4'd0 : kmod + 4'd1;
               if (kmod == 4'd0)
                  rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
               if (last_word) begin
                  o_RKeyVld <= 1'b1;
                  o_RKey    <= key_ld;
                  o_RndIdx  <= ld_r;
                  o_Last    <= dec ? (ld_r == 4'd0) : (ld_r == nr);
               end
            end
            STREAM: begin
               if (accept) begin
                  if (o_Last) begin
                     o_RKeyVld <= 1'b0;
                     o_Last    <= 1'b0;
                  end else begin
                     o_RKey   <= key_ld;
                     o_RndIdx <= ld_r;
                     o_Last   <= dec ? (ld_r == 4'd0) : (ld_r == nr);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_key_schedule_seq.sv
// Purpose: directed self-checking bench for key_schedule_seq using FIPS-197 key vectors.
// Latency: checks 40/46/52-clock expansion latency and per-beat round ordering.
// Backpressure: random ready stalls must hold the presented round key and index.
module tb_key_schedule_seq;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [255:0] key = '0;
   logic [1:0]   key_len = 2'd0;
   logic         f_dec = 1'b0;
   logic         rkey_rdy = 1'b1;
   logic         busy, rkey_vld, last, err;
   logic [127:0] rkey;
   logic [3:0]   rnd_idx;

   int checks = 0;
   int failures = 0;
   int lat;
   int n_beats;
   logic [127:0] beat_key [16];
   logic [3:0]   beat_idx [16];
   logic         beat_last [16];

   localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
   localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

   key_schedule_seq #(.MAX_NK(8)) dut (
      .i_Clk     (clk),
      .i_Rst_n   (rst_n),
      .i_Start   (start),
      .i_Key     (key),
      .i_KeyLen  (key_len),
      .i_fDec    (f_dec),
      .o_Busy    (busy),
      .o_RKey    (rkey),
      .o_RKeyVld (rkey_vld),
      .i_RKeyRdy (rkey_rdy),
      .o_RndIdx  (rnd_idx),
      .o_Last    (last),
      .o_Err     (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Start pulse over one edge; returns at the negedge right after the sampling edge.
   task automatic start_op(input logic [255:0] k, input logic [1:0] len, input logic dec);
      @(negedge clk);
      key = k; key_len = len; f_dec = dec; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Counts edges from the sampling edge until o_RKeyVld; optionally fires a start mid-expansion.
   task automatic wait_vld(input logic inject);
      logic [255:0] k0;
      k0 = key;
      lat = 0;
      while (!rkey_vld && lat < 200) begin
         start = inject && (lat == 10);
         if (start) begin key = ~k0; key_len = 2'd2; f_dec = ~f_dec; end
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      chk("vld_timeout", 128'(rkey_vld), 128'(1));
   endtask

   task automatic collect(input logic stall);
      logic [127:0] held_key;
      logic [3:0]   held_idx;
      logic         held;
      logic         done;
      held = 1'b0; done = 1'b0; held_key = '0; held_idx = '0;
      n_beats = 0;
      for (int c = 0; c < 400 && !done; c++) begin
         if (held) begin
            chk("stall_key", rkey, held_key);
            chk("stall_idx", 128'(rnd_idx), 128'(held_idx));
         end
         held = 1'b0;
         if (rkey_vld) begin
            rkey_rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rkey_rdy) begin
               if (n_beats < 16) begin
                  beat_key[n_beats] = rkey;
                  beat_idx[n_beats] = rnd_idx;
                  beat_last[n_beats] = last;
               end
               n_beats++;
               done = last;
            end else begin
               held = 1'b1; held_key = rkey; held_idx = rnd_idx;
            end
         end
         @(negedge clk);
      end
      rkey_rdy = 1'b1;
      chk("stream_done", 128'(done), 128'(1));
      chk("busy_after", 128'(busy), 128'(0));
      chk("vld_after", 128'(rkey_vld), 128'(0));
   endtask

   task automatic check_seq(input int nr, input logic dec);
      chk("beat_count", 128'(n_beats), 128'(nr + 1));
      for (int k = 0; k < n_beats && k < 16; k++) begin
         chk("beat_idx", 128'(beat_idx[k]), 128'(dec ? nr - k : k));
         chk("beat_last", 128'(beat_last[k]), 128'(k == n_beats - 1));
      end
   endtask

   initial begin
      // Reset state
      #12;
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_vld", 128'(rkey_vld), 128'(0));
      chk("rst_rkey", rkey, 128'(0));
      chk("rst_idx", 128'(rnd_idx), 128'(0));
      chk("rst_last", 128'(last), 128'(0));
      chk("rst_err", 128'(err), 128'(0));
      @(negedge clk);
      rst_n = 1'b1;

      // 1: AES-128 encrypt, always ready
      start_op(KEY128, 2'd0, 1'b0);
      chk("t1_busy", 128'(busy), 128'(1));
      wait_vld(1'b0);
      chk("t1_lat", 128'(lat), 128'(40));
      collect(1'b0);
      check_seq(10, 1'b0);
      chk("t1_r0", beat_key[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
      chk("t1_r1", beat_key[1], 128'ha0fafe1788542cb123a339392a6c7605);
      chk("t1_r10", beat_key[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      // 2: AES-192 decrypt
      start_op(KEY192, 2'd1, 1'b1);
      wait_vld(1'b0);
      chk("t2_lat", 128'(lat), 128'(46));
      collect(1'b0);
      check_seq(12, 1'b1);
      chk("t2_r12", beat_key[0], 128'he98ba06f448c773c8ecc720401002202);
      chk("t2_r0", beat_key[12], 128'h8e73b0f7da0e6452c810f32b809079e5);

      // 3: AES-256 encrypt
      start_op(KEY256, 2'd2, 1'b0);
      wait_vld(1'b0);
      chk("t3_lat", 128'(lat), 128'(52));
      collect(1'b0);
      check_seq(14, 1'b0);
      chk("t3_r0", beat_key[0], 128'h603deb1015ca71be2b73aef0857d7781);
      chk("t3_r1", beat_key[1], 128'h1f352c073b6108d72d9810a30914dff4);
      chk("t3_r14", beat_key[14], 128'hfe4890d1e6188d0b046df344706c631e);

      // 4: AES-128 encrypt with random ready stalls
      start_op(KEY128, 2'd0, 1'b0);
      wait_vld(1'b0);
      collect(1'b1);
      check_seq(10, 1'b0);
      chk("t4_r0", beat_key[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
      chk("t4_r1", beat_key[1], 128'ha0fafe1788542cb123a339392a6c7605);
      chk("t4_r10", beat_key[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      // 5a: illegal key length
      @(negedge clk);
      key_len = 2'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("t5_err", 128'(err), 128'(1));
      chk("t5_busy", 128'(busy), 128'(0));
      @(negedge clk);
      chk("t5_err_pulse", 128'(err), 128'(0));
      chk("t5_busy2", 128'(busy), 128'(0));

      // 5b: start during expansion is ignored
      start_op(KEY128, 2'd0, 1'b0);
      wait_vld(1'b1);
      chk("t5_lat", 128'(lat), 128'(40));
      collect(1'b0);
      check_seq(10, 1'b0);
      chk("t5_r0", beat_key[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
      chk("t5_r10", beat_key[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      // 6: asynchronous reset mid-expansion, then rerun AES-256
      start_op(KEY256, 2'd2, 1'b0);
      repeat (19) @(negedge clk);
      chk("t6_busy_pre", 128'(busy), 128'(1));
      #2 rst_n = 1'b0;
      #1;
      chk("t6_busy", 128'(busy), 128'(0));
      chk("t6_vld", 128'(rkey_vld), 128'(0));
      chk("t6_rkey", rkey, 128'(0));
      chk("t6_idx", 128'(rnd_idx), 128'(0));
      chk("t6_last", 128'(last), 128'(0));
      @(negedge clk);
      rst_n = 1'b1;
      start_op(KEY256, 2'd2, 1'b0);
      wait_vld(1'b0);
      chk("t6_lat", 128'(lat), 128'(52));
      collect(1'b0);
      check_seq(14, 1'b0);
      chk("t6_r14", beat_key[14], 128'hfe4890d1e6188d0b046df344706c631e);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
